// File: rtl/alu_pipe_stage_pkg.sv
// Shared ALU definitions: opcode encoding and widths used by the pipe stage
// and by the combinational ALU core.
package alu_pipe_stage_pkg;

   localparam int unsigned OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_ADD = 2'b11
   } alu_op_e;

endpackage

// File: rtl/alu_pipe_stage_logic_unit.sv
// Combinational N-bit ALU core: bitwise AND/OR/XOR and ADD with carry-out.
module alu_logic_unit
   import alu_pipe_stage_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [OP_W-1:0] op,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   output logic [N-1:0]    result,
   output logic            carry
);

   logic [N:0] sum;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      result = '0;
      carry  = 1'b0;
      case (alu_op_e'(op))
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_ADD: begin
            result = sum[N-1:0];
            carry  = sum[N];
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_pipe_stage.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds the
// result and flags; counts results accepted downstream.
module alu_pipe_stage
   import alu_pipe_stage_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     result,
   output logic             carry,
   output logic             zero,
   output logic [CNT_W-1:0] op_count
);

   logic            ready_en;
   logic            s1_valid;
   logic [OP_W-1:0] s1_op;
   logic [N-1:0]    s1_a;
   logic [N-1:0]    s1_b;
   logic            s2_valid;

   logic            s2_free;
   logic            s1_adv;
   logic            in_fire;
   logic            out_fire;

   logic [N-1:0]    alu_result;
   logic            alu_carry;

   alu_logic_unit #(.N(N)) u_alu (
      .op     (s1_op),
      .a      (s1_a),
      .b      (s1_b),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // Handshake: in_ready depends only on stage state and out_ready, never on in_valid.
   always_comb begin
      s2_free  = !s2_valid || out_ready;
      s1_adv   = s1_valid && s2_free;
      out_fire = s2_valid && out_ready;
      in_ready = ready_en && (!s1_valid || s1_adv);
      in_fire  = in_valid && in_ready;
   end

   assign out_valid = s2_valid;

   // Input acceptance is held off until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_a     <= a;
            s1_b     <= b;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // S2 only changes when loading a new result, so outputs hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         result   <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
      end else begin
         if (s1_adv) begin
            s2_valid <= 1'b1;
            result   <= alu_result;
            carry    <= alu_carry;
            zero     <= (alu_result == '0);
         end else if (out_fire) begin
            s2_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        op_count <= '0;
      else if (out_fire) op_count <= op_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_alu_pipe_stage.sv
// Self-checking bench for alu_pipe_stage: queue-based reference model checked
// every cycle, plus directed literal cases and randomized traffic.
module tb_alu_pipe_stage;

   localparam int unsigned N     = 4;
   localparam int unsigned CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [N-1:0]     in_a;
   logic [N-1:0]     in_b;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     result;
   logic             carry;
   logic             zero;
   logic [CNT_W-1:0] op_count;

   alu_pipe_stage #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (in_op),
      .a         (in_a),
      .b         (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .op_count  (op_count)
   );

   typedef struct {
      logic [1:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
   } in_t;

   typedef struct {
      logic [N-1:0] res;
      logic         c;
      logic         z;
      int           acc;
   } exp_t;

   in_t              pend[$];
   exp_t             q[$];
   int               edge_n = 0;
   logic [CNT_W-1:0] mcnt = '0;
   bit               rdy_en = 0;
   bit               took = 0;
   int               mode = 0;
   int               n_cmp = 0;
   int               n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t ref_op(input in_t x);
      exp_t e;
      int   ai, bi, r;
      ai = int'(x.a);
      bi = int'(x.b);
      e.c = 1'b0;
      case (x.op)
         2'd0:    r = ai & bi;
         2'd1:    r = ai | bi;
         2'd2:    r = ai ^ bi;
         default: begin
            r   = ai + bi;
            e.c = (r >= (1 << N));
            r   = r % (1 << N);
         end
      endcase
      e.res = N'(r);
      e.z   = (r == 0);
      e.acc = 0;
      return e;
   endfunction

   function automatic in_t mk(input int op, input int a, input int b);
      in_t x;
      x.op = 2'(op);
      x.a  = N'(a);
      x.b  = N'(b);
      return x;
   endfunction

   function automatic bit model_out_valid();
      return (q.size() > 0) && (q[0].acc < edge_n);
   endfunction

   function automatic bit model_in_ready();
      return rdy_en && ((q.size() < 2) || out_ready);
   endfunction

   // Reference model: the stage is an in-order FIFO of depth 2; an entry becomes
   // visible one edge after acceptance, and only the oldest entry is visible.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mcnt   = '0;
         rdy_en = 0;
         edge_n = 0;
         took   = 0;
      end else begin
         bit   ov, ir;
         exp_t e;
         in_t  x;
         ov   = model_out_valid();
         ir   = model_in_ready();
         took = 0;
         if (ov && out_ready) begin
            void'(q.pop_front());
            mcnt = mcnt + CNT_W'(1);
         end
         if (in_valid && ir) begin
            x.op  = in_op;
            x.a   = in_a;
            x.b   = in_b;
            e     = ref_op(x);
            e.acc = edge_n + 1;
            q.push_back(e);
            took  = 1;
         end
         edge_n++;
         rdy_en = 1;
      end
   end

   // Driver: presents pending operations and out_ready per mode (0: ready, 1: stalled, 2: random).
   always @(posedge clk) begin
      #1;
      if (took && pend.size() > 0) void'(pend.pop_front());
      case (mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ($urandom % 3) != 0;
      endcase
      if (!(in_valid && !took && pend.size() > 0))
         in_valid = (pend.size() > 0) && (mode != 2 || ($urandom % 4) != 0);
      if (in_valid) begin
         in_op = pend[0].op;
         in_a  = pend[0].a;
         in_b  = pend[0].b;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_op_count", 32'(op_count), 32'd0);
      end else begin
         chk("out_valid", 32'(out_valid), 32'(model_out_valid()));
         chk("in_ready", 32'(in_ready), 32'(model_in_ready()));
         chk("op_count", 32'(op_count), 32'(mcnt));
         if (model_out_valid()) begin
            chk("result", 32'(result), 32'(q[0].res));
            chk("carry", 32'(carry), 32'(q[0].c));
            chk("zero", 32'(zero), 32'(q[0].z));
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      pend.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while ((pend.size() > 0 || q.size() > 0) && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (k >= budget) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: pending %0d in-flight %0d after %0d cycles", pend.size(), q.size(), k);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      mode      = 0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after_release", 32'(in_ready), 32'd1);
      chk("out_valid_after_release", 32'(out_valid), 32'd0);

      // AND 1100 & 1010: visible two cycles after presentation.
      @(posedge clk);
      pend.push_back(mk(0, 4'b1100, 4'b1010));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("and_valid", 32'(out_valid), 32'd1);
      chk("and_result", 32'(result), 32'b1000);
      chk("and_carry", 32'(carry), 32'd0);
      chk("and_zero", 32'(zero), 32'd0);

      // ADD overflow to zero, then XOR self-cancel on the following cycle.
      @(posedge clk);
      pend.push_back(mk(3, 4'b1111, 4'b0001));
      pend.push_back(mk(2, 4'b0101, 4'b0101));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("add_result", 32'(result), 32'd0);
      chk("add_carry", 32'(carry), 32'd1);
      chk("add_zero", 32'(zero), 32'd1);
      @(negedge clk);
      chk("xor_valid", 32'(out_valid), 32'd1);
      chk("xor_result", 32'(result), 32'd0);
      chk("xor_carry", 32'(carry), 32'd0);
      chk("xor_zero", 32'(zero), 32'd1);
      wait_drain(50);

      // Six back-to-back operations on consecutive cycles.
      do_reset();
      repeat (2) @(posedge clk);
      for (int i = 0; i < 6; i++) pend.push_back(mk($urandom % 4, $urandom % 16, $urandom % 16));
      repeat (2) @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("b2b_valid", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      chk("b2b_valid_end", 32'(out_valid), 32'd0);
      chk("b2b_count", 32'(op_count), 32'd6);

      // Backpressure: two accepted, third held, then all delivered.
      @(posedge clk);
      mode = 1;
      pend.push_back(mk(1, 4'b0011, 4'b0101));
      pend.push_back(mk(3, 4'b0111, 4'b0110));
      pend.push_back(mk(0, 4'b1111, 4'b0000));
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'b0111);
      @(negedge clk);
      chk("bp_result_hold", 32'(result), 32'b0111);
      chk("bp_pending", 32'(pend.size()), 32'd1);
      @(posedge clk);
      mode = 0;
      wait_drain(50);
      chk("bp_count", 32'(op_count), 32'd9);

      // Reset with both stages full discards everything immediately.
      @(posedge clk);
      mode = 1;
      pend.push_back(mk(2, 4'b1010, 4'b0110));
      pend.push_back(mk(3, 4'b1000, 4'b1000));
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_result", 32'(result), 32'b1100);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      pend.delete();
      mode = 0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_result", 32'(result), 32'd0);
      chk("async_carry", 32'(carry), 32'd0);
      chk("async_zero", 32'(zero), 32'd0);
      chk("async_count", 32'(op_count), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_idle", 32'(out_valid), 32'd0);
      end

      // 256 transfers wrap the counter back to zero.
      @(posedge clk);
      for (int i = 0; i < 256; i++) pend.push_back(mk($urandom % 4, $urandom % 16, $urandom % 16));
      wait_drain(600);
      chk("wrap_count", 32'(op_count), 32'd0);

      // Random traffic with random gaps and backpressure.
      @(posedge clk);
      mode = 2;
      for (int i = 0; i < 300; i++) pend.push_back(mk($urandom % 4, $urandom % 16, $urandom % 16));
      wait_drain(5000);
      mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("final_idle", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
